// File: rtl/spi_seq_pkg.sv
`default_nettype none
// spi_seq_pkg: op codes, primitive controller commands and sequencer state encodings. Rev 1.0
package spi_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_PROG   = 2'd1,
    OP_SERASE = 2'd2,
    OP_CERASE = 2'd3
  } op_code_e;

  localparam logic [3:0] CMD_NOP  = 4'h0;
  localparam logic [3:0] CMD_WREN = 4'h1;
  localparam logic [3:0] CMD_RDSR = 4'h2;
  localparam logic [3:0] CMD_READ = 4'h3;
  localparam logic [3:0] CMD_PP   = 4'h4;
  localparam logic [3:0] CMD_SE   = 4'h5;
  localparam logic [3:0] CMD_CE   = 4'h6;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t ST_IDLE     = 3'd0;
  localparam seq_state_t ST_WREN     = 3'd1;
  localparam seq_state_t ST_PRIM     = 3'd2;
  localparam seq_state_t ST_POLL_GAP = 3'd3;
  localparam seq_state_t ST_POLL     = 3'd4;
  localparam seq_state_t ST_CHECK    = 3'd5;
  localparam seq_state_t ST_VERIFY   = 3'd6;
  localparam seq_state_t ST_FINISH   = 3'd7;

  localparam int WIP_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/spi_seq_issue.sv
`default_nettype none
// spi_seq_issue: launches one controller primitive, waits out busy and captures any returned byte. Rev 1.0
module spi_seq_issue
  import spi_seq_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_i,
  input  logic        capture_i,
  input  logic [3:0]  cmd_i,
  input  logic [31:0] addr_i,
  input  logic [7:0]  wdata_i,
  input  logic        ctl_busy_i,
  input  logic        ctl_rvalid_i,
  input  logic [7:0]  ctl_rdata_i,
  output logic        ctl_start_o,
  output logic [3:0]  ctl_cmd_o,
  output logic [31:0] ctl_addr_o,
  output logic [7:0]  ctl_wdata_o,
  output logic        prim_done_o,
  output logic        rgot_o,
  output logic [7:0]  rbyte_o
);

  localparam logic [1:0] IS_IDLE  = 2'd0;
  localparam logic [1:0] IS_ISSUE = 2'd1;
  localparam logic [1:0] IS_SKIP  = 2'd2;
  localparam logic [1:0] IS_WAIT  = 2'd3;

  logic [1:0]  st_q, st_d;
  logic [3:0]  cmd_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  byte_q;
  logic        cap_q;
  logic        got_q;
  logic        w_launch;
  logic        w_hit;

  assign w_launch = (st_q == IS_IDLE) && req_i && !ctl_busy_i;
  assign w_hit    = cap_q && ctl_rvalid_i && (st_q != IS_IDLE);

  // The cycle after the launch pulse ignores busy so the controller has time to raise it.
  always_comb begin
    st_d = st_q;
    case (st_q)
      IS_IDLE:  if (w_launch) st_d = IS_ISSUE;
      IS_ISSUE: st_d = IS_SKIP;
      IS_SKIP:  st_d = IS_WAIT;
      IS_WAIT:  if (!ctl_busy_i) st_d = IS_IDLE;
      default:  st_d = IS_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      st_q    <= IS_IDLE;
      cmd_q   <= CMD_NOP;
      addr_q  <= 32'h0;
      wdata_q <= 8'h0;
      byte_q  <= 8'h0;
      cap_q   <= 1'b0;
      got_q   <= 1'b0;
    end else begin
      st_q <= st_d;
      if (w_launch) begin
        cmd_q   <= cmd_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        cap_q   <= capture_i;
        got_q   <= 1'b0;
      end else if (w_hit) begin
        byte_q <= ctl_rdata_i;
        got_q  <= 1'b1;
      end
    end
  end

  assign ctl_start_o = (st_q == IS_ISSUE);
  assign ctl_cmd_o   = cmd_q;
  assign ctl_addr_o  = addr_q;
  assign ctl_wdata_o = wdata_q;
  assign prim_done_o = (st_q == IS_WAIT) && !ctl_busy_i;
  assign rgot_o      = got_q | w_hit;
  assign rbyte_o     = w_hit ? ctl_rdata_i : byte_q;

endmodule
`default_nettype wire

// File: rtl/spi_flash_op_sequencer.sv
`default_nettype none
// spi_flash_op_sequencer: expands READ/PROG/ERASE into controller primitives with busy polling. Rev 1.0
// Optional readback check of programmed bytes: define SPI_SEQ_READBACK_VERIFY_EN.
module spi_flash_op_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          POLL_GAP = 16,
  parameter logic [19:0] POLL_MAX = 20'hFFFFF,
  parameter int          ADDR_W   = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [7:0]        op_wdata,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              err,
  output logic [3:0]        ctl_cmd,
  output logic [31:0]       ctl_addr,
  output logic [7:0]        ctl_wdata,
  output logic              ctl_start,
  input  logic              ctl_busy,
  input  logic              ctl_rvalid,
  input  logic [7:0]        ctl_rdata
);

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  seq_state_t        st_q, st_d;
  op_code_e          code_q, code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [15:0]       gap_q, gap_d;
  logic [19:0]       pcnt_q, pcnt_d;
  logic              wip_q, wip_d;
  logic              err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;

  logic        w_req, w_cap;
  logic [3:0]  w_cmd;
  logic [31:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_prim_done, w_rgot;
  logic [7:0]  w_rbyte;
  logic [19:0] w_pcnt_inc;

  assign w_pcnt_inc = (pcnt_q == POLL_MAX) ? POLL_MAX : pcnt_q + 20'd1;

  always_comb begin
    w_req   = 1'b0;
    w_cap   = 1'b0;
    w_cmd   = CMD_NOP;
    w_addr  = 32'h0;
    w_wdata = 8'h0;
    case (st_q)
      ST_WREN: begin
        w_req = 1'b1;
        w_cmd = CMD_WREN;
      end
      ST_PRIM: begin
        w_req  = 1'b1;
        w_addr = 32'(addr_q);
        case (code_q)
          OP_READ: begin
            w_cmd = CMD_READ;
            w_cap = 1'b1;
          end
          OP_PROG: begin
            w_cmd   = CMD_PP;
            w_wdata = wdata_q;
          end
          OP_SERASE: w_cmd = CMD_SE;
          default: begin
            w_cmd  = CMD_CE;
            w_addr = 32'h0;
          end
        endcase
      end
      ST_POLL: begin
        w_req = 1'b1;
        w_cap = 1'b1;
        w_cmd = CMD_RDSR;
      end
`ifdef SPI_SEQ_READBACK_VERIFY_EN
      ST_VERIFY: begin
        w_req  = 1'b1;
        w_cap  = 1'b1;
        w_cmd  = CMD_READ;
        w_addr = 32'(addr_q);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    code_d  = code_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gap_d   = gap_q;
    pcnt_d  = pcnt_q;
    wip_d   = wip_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (st_q)
      ST_IDLE: if (op_valid) begin
        code_d  = op_code_e'(op_code);
        addr_d  = op_addr;
        wdata_d = op_wdata;
        err_d   = 1'b0;
        pcnt_d  = 20'd0;
        st_d    = (op_code == OP_READ) ? ST_PRIM : ST_WREN;
      end
      ST_WREN: if (w_prim_done) st_d = ST_PRIM;
      ST_PRIM: if (w_prim_done) begin
        if (code_q == OP_READ) begin
          if (w_rgot) rdata_d = w_rbyte;
          st_d = ST_FINISH;
        end else begin
          gap_d = 16'd0;
          st_d  = ST_POLL_GAP;
        end
      end
      ST_POLL_GAP: begin
        if (gap_q == GAP_LAST) st_d = ST_POLL;
        else                   gap_d = gap_q + 16'd1;
      end
      // A status poll that returns no byte is treated as still busy.
      ST_POLL: if (w_prim_done) begin
        wip_d = w_rgot ? w_rbyte[WIP_BIT] : 1'b1;
        st_d  = ST_CHECK;
      end
      ST_CHECK: begin
        if (!wip_q) begin
`ifdef SPI_SEQ_READBACK_VERIFY_EN
          st_d = (code_q == OP_PROG) ? ST_VERIFY : ST_FINISH;
`else
          st_d = ST_FINISH;
`endif
        end else begin
          pcnt_d = w_pcnt_inc;
          if (w_pcnt_inc == POLL_MAX) begin
            err_d = 1'b1;
            st_d  = ST_FINISH;
          end else begin
            gap_d = 16'd0;
            st_d  = ST_POLL_GAP;
          end
        end
      end
`ifdef SPI_SEQ_READBACK_VERIFY_EN
      ST_VERIFY: if (w_prim_done) begin
        if (w_rgot) rdata_d = w_rbyte;
        err_d = !w_rgot || (w_rbyte != wdata_q);
        st_d  = ST_FINISH;
      end
`endif
      ST_FINISH: st_d = ST_IDLE;
      default:   st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      st_q    <= ST_IDLE;
      code_q  <= OP_READ;
      addr_q  <= '0;
      wdata_q <= 8'h0;
      gap_q   <= 16'd0;
      pcnt_q  <= 20'd0;
      wip_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h0;
    end else begin
      st_q    <= st_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gap_q   <= gap_d;
      pcnt_q  <= pcnt_d;
      wip_q   <= wip_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  spi_seq_issue u_issue (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_i        (w_req),
    .capture_i    (w_cap),
    .cmd_i        (w_cmd),
    .addr_i       (w_addr),
    .wdata_i      (w_wdata),
    .ctl_busy_i   (ctl_busy),
    .ctl_rvalid_i (ctl_rvalid),
    .ctl_rdata_i  (ctl_rdata),
    .ctl_start_o  (ctl_start),
    .ctl_cmd_o    (ctl_cmd),
    .ctl_addr_o   (ctl_addr),
    .ctl_wdata_o  (ctl_wdata),
    .prim_done_o  (w_prim_done),
    .rgot_o       (w_rgot),
    .rbyte_o      (w_rbyte)
  );

  assign op_ready = (st_q == ST_IDLE);
  assign done     = (st_q == ST_FINISH);
  assign err      = done & err_q;
  assign rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_op_sequencer.sv
`default_nettype none
// tb_spi_flash_op_sequencer: directed operations against a small flash-controller model with queued expectations.
module tb_spi_flash_op_sequencer;

  localparam int          POLL_GAP_TB = 4;
  localparam logic [19:0] POLL_MAX_TB = 20'd8;
  localparam int          BUSY_LEN    = 3;
  localparam logic [3:0]  C_NOP = 4'h0, C_WREN = 4'h1, C_RDSR = 4'h2, C_READ = 4'h3;
  localparam logic [3:0]  C_PP  = 4'h4, C_SE   = 4'h5, C_CE   = 4'h6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [23:0] op_addr = 24'h0;
  logic [7:0]  op_wdata = 8'h0;
  logic        op_ready, done, err, ctl_start;
  logic [7:0]  rdata, ctl_wdata;
  logic [3:0]  ctl_cmd;
  logic [31:0] ctl_addr;
  logic        ctl_busy = 1'b0;
  logic        ctl_rvalid = 1'b0;
  logic [7:0]  ctl_rdata = 8'h0;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } cmd_t;
  typedef struct packed {
    logic [7:0] rd;
    logic       er;
  } done_t;

  cmd_t  exp_cmd[$];
  done_t exp_done[$];
  cmd_t  m_e;
  done_t d_e;

  int n_pass = 0, n_total = 0, done_cnt = 0, cyc = 0, last_rdsr = -1, m_cnt = 0, wip_left = 0;
  logic       stuck = 1'b0, suppress = 1'b0, ready_pending = 1'b0;
  logic [3:0] m_cmd = 4'h0;
  logic [7:0] read_byte = 8'h0, exp_rd = 8'h0;

  spi_flash_op_sequencer #(
    .POLL_GAP (POLL_GAP_TB),
    .POLL_MAX (POLL_MAX_TB),
    .ADDR_W   (24)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_addr    (op_addr),
    .op_wdata   (op_wdata),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .ctl_cmd    (ctl_cmd),
    .ctl_addr   (ctl_addr),
    .ctl_wdata  (ctl_wdata),
    .ctl_start  (ctl_start),
    .ctl_busy   (ctl_busy),
    .ctl_rvalid (ctl_rvalid),
    .ctl_rdata  (ctl_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic push_cmd(input logic [3:0] c, input logic [31:0] a, input logic [7:0] w);
    exp_cmd.push_back('{cmd: c, addr: a, wdata: w});
  endtask

  task automatic push_done(input logic [7:0] r, input logic e);
    exp_done.push_back('{rd: r, er: e});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_ctl_start"}, 32'(ctl_start), 32'd0);
    chk({tag, "_ctl_cmd"}, 32'(ctl_cmd), 32'(C_NOP));
    chk({tag, "_ctl_addr"}, ctl_addr, 32'd0);
    chk({tag, "_ctl_wdata"}, 32'(ctl_wdata), 32'd0);
  endtask

  task automatic issue_op(input logic [1:0] c, input logic [23:0] a, input logic [7:0] w);
    int t = 0;
    @(negedge clk);
    while (!op_ready && t < 500) begin @(negedge clk); t++; end
    if (!op_ready) chk("issue_ready_timeout", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_code = c; op_addr = a; op_wdata = w;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin @(negedge clk); t++; end
    if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  // Controller model and primitive-command monitor.
  always @(negedge clk) begin
    if (ctl_start) begin
      chk("start_while_busy", 32'(ctl_busy), 32'd0);
      if (exp_cmd.size() == 0) begin
        chk("unexpected_start", 32'(ctl_cmd), 32'(C_NOP));
      end else begin
        m_e = exp_cmd.pop_front();
        chk("ctl_cmd", 32'(ctl_cmd), 32'(m_e.cmd));
        chk("ctl_addr", ctl_addr, m_e.addr);
        chk("ctl_wdata", 32'(ctl_wdata), 32'(m_e.wdata));
      end
      if (ctl_cmd == C_RDSR) begin
        if (last_rdsr >= 0) chk("poll_gap_ok", 32'((cyc - last_rdsr) >= POLL_GAP_TB), 32'd1);
        last_rdsr = cyc;
      end else begin
        last_rdsr = -1;
      end
      m_cmd = ctl_cmd; m_cnt = BUSY_LEN; ctl_busy = 1'b1; ctl_rvalid = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        ctl_busy = 1'b0;
        if (m_cmd == C_RDSR) begin
          ctl_rvalid = 1'b1;
          if (stuck) ctl_rdata = 8'h03;
          else if (wip_left > 0) begin ctl_rdata = 8'h03; wip_left--; end
          else ctl_rdata = 8'h00;
        end else if (m_cmd == C_READ && !suppress) begin
          ctl_rvalid = 1'b1;
          ctl_rdata  = read_byte;
        end
      end
    end else begin
      ctl_rvalid = 1'b0;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (ready_pending) begin
      chk("ready_after_done", 32'(op_ready), 32'd1);
      ready_pending = 1'b0;
    end
    if (done) begin
      chk("ready_low_at_done", 32'(op_ready), 32'd0);
      if (exp_done.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        d_e = exp_done.pop_front();
        chk("rdata", 32'(rdata), 32'(d_e.rd));
        chk("err", 32'(err), 32'(d_e.er));
      end
      done_cnt++;
      ready_pending = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    read_byte = 8'hA5; exp_rd = 8'hA5;
    push_cmd(C_READ, 32'h0000_0100, 8'h00);
    push_done(exp_rd, 1'b0);
    issue_op(2'd0, 24'h000100, 8'h00);
    wait_done(1);

    wip_left = 3;
    push_cmd(C_WREN, 32'h0, 8'h00);
    push_cmd(C_PP, 32'h0000_1000, 8'h3C);
    repeat (4) push_cmd(C_RDSR, 32'h0, 8'h00);
`ifdef SPI_SEQ_READBACK_VERIFY_EN
    read_byte = 8'h3C; exp_rd = 8'h3C;
    push_cmd(C_READ, 32'h0000_1000, 8'h00);
`endif
    push_done(exp_rd, 1'b0);
    issue_op(2'd1, 24'h001000, 8'h3C);
    wait_done(2);

    stuck = 1'b1;
    push_cmd(C_WREN, 32'h0, 8'h00);
    push_cmd(C_SE, 32'h0002_0000, 8'h00);
    repeat (8) push_cmd(C_RDSR, 32'h0, 8'h00);
    push_done(exp_rd, 1'b1);
    issue_op(2'd2, 24'h020000, 8'h00);
    wait_done(3);
    stuck = 1'b0;

    wip_left = 0;
    repeat (2) begin
      push_cmd(C_WREN, 32'h0, 8'h00);
      push_cmd(C_CE, 32'h0, 8'h00);
      push_cmd(C_RDSR, 32'h0, 8'h00);
      push_done(exp_rd, 1'b0);
    end
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'd3; op_addr = 24'hABCDEF; op_wdata = 8'h77;
    wait_done(4);
    t = 0;
    do begin @(negedge clk); t++; end while (op_ready && t < 50);
    chk("held_valid_second_accept", 32'(op_ready), 32'd0);
    op_valid = 1'b0;
    wait_done(5);

    stuck = 1'b1;
    push_cmd(C_WREN, 32'h0, 8'h00);
    push_cmd(C_PP, 32'h0000_2000, 8'h99);
    push_cmd(C_RDSR, 32'h0, 8'h00);
    issue_op(2'd1, 24'h002000, 8'h99);
    t = 0;
    while (!(ctl_start && ctl_cmd == C_RDSR) && t < 500) begin @(negedge clk); t++; end
    chk("reached_poll", 32'(ctl_cmd), 32'(C_RDSR));
    #2 rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    stuck = 1'b0;
    read_byte = 8'h5A; exp_rd = 8'h5A;
    push_cmd(C_READ, 32'h0000_ABCD, 8'h00);
    push_done(exp_rd, 1'b0);
    issue_op(2'd0, 24'h00ABCD, 8'h00);
    wait_done(6);

    suppress = 1'b1;
    push_cmd(C_READ, 32'h0000_0044, 8'h00);
    push_done(exp_rd, 1'b0);
    issue_op(2'd0, 24'h000044, 8'h00);
    wait_done(7);
    suppress = 1'b0;

`ifdef SPI_SEQ_READBACK_VERIFY_EN
    wip_left = 0; read_byte = 8'h54; exp_rd = 8'h54;
    push_cmd(C_WREN, 32'h0, 8'h00);
    push_cmd(C_PP, 32'h0000_3000, 8'h55);
    push_cmd(C_RDSR, 32'h0, 8'h00);
    push_cmd(C_READ, 32'h0000_3000, 8'h00);
    push_done(exp_rd, 1'b1);
    issue_op(2'd1, 24'h003000, 8'h55);
    wait_done(8);
`endif

    repeat (5) @(negedge clk);
    chk("cmds_outstanding", 32'(exp_cmd.size()), 32'd0);
    chk("dones_outstanding", 32'(exp_done.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_op_sequencer.md
Name: spi_flash_op_sequencer

Overview:
- Sits between user logic and SPI_flash_controller.
- Turns one high-level flash operation into the required sequence of primitive controller commands:
  - read: single READ.
  - program byte: WREN -> PP -> RDSR poll until WIP=0.
  - sector/chip erase: WREN -> SE/CE -> RDSR poll until WIP=0.
- Owns busy-polling and timeout, so user logic never touches the controller directly.

Parameters:
- POLL_GAP, 16: idle cycles between RDSR polls.
- POLL_MAX, 20'hFFFFF: maximum RDSR polls before timeout error.
- ADDR_W, 24: flash address width; zero-extended to 32 bits on ctl_addr.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous reset, active-high.
- op_valid  in  1  operation request.
- op_ready  out  1  sequencer accepts a request (high only in IDLE).
- op_code  in  2  0=READ, 1=PROG, 2=SERASE, 3=CERASE.
- op_addr  in  ADDR_W  byte address (ignored for CERASE).
- op_wdata  in  8  byte to program.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  read byte; valid when done and op was READ.
- err  out  1  qualified by done: poll timeout or verify mismatch.
- ctl_cmd  out  4  primitive command to controller.
- ctl_addr  out  32  address to controller.
- ctl_wdata  out  8  write byte to controller.
- ctl_start  out  1  one-cycle launch pulse.
- ctl_busy  in  1  controller busy.
- ctl_rvalid  in  1  controller read-data strobe.
- ctl_rdata  in  8  controller read data.

Behaviour:
- Reset (sys_rst_n=1, asynchronous), outputs:
  - op_ready=1, done=0, err=0, rdata=0, ctl_start=0.
  - ctl_cmd=CMD_NOP, ctl_addr=0, ctl_wdata=0.
  - State IDLE; counters cleared.
- Accept rule:
  - A request is accepted on the cycle op_valid && op_ready.
  - op_code, op_addr and op_wdata are latched on that cycle.
  - op_ready drops the next cycle and stays low until the cycle after done.
- Primitive issue (common to every primitive):
  - Enter an ISSUE state only when ctl_busy=0.
  - Drive ctl_cmd/ctl_addr/ctl_wdata and a one-cycle ctl_start.
  - In the following WAIT state, ignore ctl_busy for 1 cycle, then wait for ctl_busy=0.
- FSM states: IDLE, WREN, PRIM, POLL_GAP, POLL, CHECK, VERIFY, FINISH.
- Transitions:
  - IDLE -> WREN for PROG/SERASE/CERASE; IDLE -> PRIM for READ.
  - WREN: issue CMD_WREN -> PRIM.
  - PRIM: issue CMD_READ/CMD_PP/CMD_SE/CMD_CE.
    - READ: capture ctl_rdata on ctl_rvalid -> FINISH.
    - Others -> POLL_GAP.
  - POLL_GAP: count POLL_GAP cycles -> POLL.
  - POLL: issue CMD_RDSR; capture status byte on ctl_rvalid -> CHECK.
  - CHECK:
    - status[0]=0 -> FINISH (or VERIFY for PROG when feature enabled).
    - Else increment poll count.
    - Poll count == POLL_MAX -> FINISH with err=1.
    - Else -> POLL_GAP.
  - FINISH: done=1 for one cycle; err as determined -> IDLE.
- rdata holds its last value until the next READ completes.
- Poll counter is 20 bits and saturates at POLL_MAX; it never wraps.
- ctl_rvalid outside a read or RDSR wait is ignored.
- If READ completes with no ctl_rvalid, rdata keeps its old value and err=0.
- op_valid is ignored while op_ready=0; requests are not queued.
- Reset mid-operation aborts immediately to IDLE. The flash may still be busy, so the first op after reset simply polls as normal.

Optional Feature:
- Macro SPI_SEQ_READBACK_VERIFY_EN.
- Defined: after a PROG completes polling, enter VERIFY and issue CMD_READ at the same address.
  - Readback != latched op_wdata -> done with err=1.
  - rdata is updated with the readback byte.
- Undefined: the VERIFY state and comparator are absent; PROG goes CHECK -> FINISH with err=0 unless timeout.

Decomposition:
- Package spi_seq_pkg:
  - op_code enum: OP_READ, OP_PROG, OP_SERASE, OP_CERASE.
  - Primitive command constants: CMD_NOP=4'h0, CMD_WREN=4'h1, CMD_RDSR=4'h2, CMD_READ=4'h3, CMD_PP=4'h4, CMD_SE=4'h5, CMD_CE=4'h6.
  - FSM state enum.
  - WIP_BIT=0.
- One sub-module: spi_seq_issue.
  - Per-primitive start/wait-busy/capture-rvalid handshake.
  - Returns a prim_done pulse plus the captured byte.

Test Plan:
- READ at 24'h000100, controller model returns 8'hA5 -> sequence CMD_READ only, done with rdata=8'hA5, err=0, op_ready back high the cycle after done.
- PROG 8'h3C at 24'h001000, model status WIP=1 for 3 polls then 0 -> sequence WREN, PP, 4 RDSR polls, each POLL_GAP+ cycles apart; done with err=0.
- SERASE at 24'h020000 with WIP stuck at 1, POLL_MAX=8 -> exactly 8 RDSR after SE, then done with err=1.
- CERASE with op_valid held high during operation -> second op accepted only after done; no ctl_start while ctl_busy=1.
- Reset asserted during POLL -> all outputs at reset values next cycle; a following READ completes correctly.
- With SPI_SEQ_READBACK_VERIFY_EN: PROG 8'h55, model readback 8'h54 -> extra CMD_READ after polling, done with err=1 and rdata=8'h54.
